program_memory: RTL and testbench
=================================

Name: program_memory

Overview:
Instruction-side responder for golden_core. It stores the program and returns `instruction` for the core's `pc` combinationally, in the same cycle. It contains a byte-stream loader that keeps the core in reset while it clears memory to `NOP` and then fills it from a host stream. When loading finishes it releases the core.

Parameters:
DEPTH, 2**`ADDRESS_SIZE, number of `INSTRUCTION_SIZE-bit words stored.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
pc  input  `ADDRESS_SIZE  word address from golden_core.
instruction  output  `INSTRUCTION_SIZE  word returned to golden_core.
core_reset  output  1  active-low reset driven to golden_core.
load_start  input  1  one-cycle pulse that requests a new load.
load_valid  input  1  host byte valid.
load_byte  input  8  host data byte; high byte of each instruction first.
load_last  input  1  qualifies the final byte of the program.
load_ready  output  1  block can accept a byte.
load_done  output  1  high while the loaded program is running.
load_error  output  1  sticky error flag; cleared by the next load_start or by reset.
load_count  output  `ADDRESS_SIZE+1  number of words written in the last load.

Behaviour:
- Reset values (asynchronous, reset=0):
  - state=CLEAR, clear pointer=0, write pointer=0.
  - core_reset=0, load_ready=0, load_done=0, load_error=0, load_count=0.
  - Memory contents are not reset.
- States: CLEAR, HOLD, LOAD_HI, LOAD_LO, RUN.
- CLEAR:
  - Writes `NOP to mem[clear pointer] each cycle and increments the pointer.
  - After the write of word DEPTH-1 (DEPTH cycles in total), goes to HOLD.
  - load_start is ignored in CLEAR.
- HOLD:
  - core_reset=0.
  - load_start moves to LOAD_HI, clears load_error and load_count, and sets write pointer=0.
- LOAD_HI:
  - load_ready=1.
  - On load_valid&&load_ready, latch load_byte into the high-byte register and go to LOAD_LO.
  - load_last together with a high byte is an odd-length stream: set load_error and go to HOLD. Nothing is written.
- LOAD_LO:
  - load_ready=1.
  - On handshake, write mem[write pointer] = {high byte, load_byte} at that edge, increment the write pointer and load_count.
  - If load_last=1, go to RUN. Otherwise go to LOAD_HI.
- Overflow: a high-byte handshake while write pointer == DEPTH sets load_error and goes to HOLD. Words already written stay in memory.
- RUN:
  - core_reset=1 and load_done=1, both registered: the first RUN cycle after the final write.
  - load_ready=0.
  - load_start returns to CLEAR: core_reset=0 and load_done=0 from the next edge.
- instruction:
  - In RUN: mem[pc], combinational with no added latency. Any pc change is reflected in the same cycle.
  - In every other state: `NOP.
- load_valid without load_ready is ignored. The host holds load_byte stable until the handshake.
- load_start while in LOAD_HI or LOAD_LO aborts the load: return to CLEAR, load_error=1.
- Asynchronous reset in any state, including mid-load or mid-RUN:
  - Forces core_reset=0 immediately, not waiting for a clock edge.
  - Restarts from CLEAR.

Test Plan:
1. Reset, then wait DEPTH cycles -> state HOLD, core_reset=0, load_ready=0. With pc swept 0..7, instruction = `NOP.
2. load_start, then send bytes {`LOADC,`R0} and 8'h0D, then {`LOADC,`R1} and 8'h0E with load_last -> load_count=2, core_reset=1 and load_done=1 on the following cycle. pc=0 gives {`LOADC,`R0,8'h0D}, pc=1 gives {`LOADC,`R1,8'h0E}, pc=2 gives `NOP.
3. Hold load_valid=0 for 3 cycles between a high byte and its low byte, and toggle load_valid while load_ready=0 -> no spurious write; load_count increments only on the low-byte handshake.
4. Send 3 bytes with load_last on the third -> load_error=1, state HOLD, core_reset stays 0, load_count=1.
5. Send 2*DEPTH+2 bytes with no load_last -> load_error=1 on byte 2*DEPTH+1, load_count=DEPTH.
6. Drop reset while in RUN and again mid-load -> core_reset=0 and load_done=0 asynchronously. A reload of 9 words ending in `HALT then executes: bench drives pc 0..8 and checks instruction against the loaded words.

Source files
------------

// File: rtl/program_memory.sv
// program_memory: instruction store for golden_core with a byte-stream loader.
// After reset the whole array is filled with NOP while the core is held in
// reset. The host then streams 16-bit instructions high byte first, and the
// core is released once the final word is written. The core fetches through
// a combinational read port that returns NOP unless a program is running.

`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 4
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 16
`endif
`ifndef NOP
`define NOP 16'hE000
`endif
`ifndef HALT
`define HALT 16'hF000
`endif
`ifndef LOADC
`define LOADC 4'h1
`endif
`ifndef R0
`define R0 4'h0
`endif
`ifndef R1
`define R1 4'h1
`endif

module program_memory #(
    parameter int DEPTH = 2**`ADDRESS_SIZE
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [`ADDRESS_SIZE-1:0]      pc,
    output logic [`INSTRUCTION_SIZE-1:0]  instruction,
    output logic                          core_reset,
    input  logic                          load_start,
    input  logic                          load_valid,
    input  logic [7:0]                    load_byte,
    input  logic                          load_last,
    output logic                          load_ready,
    output logic                          load_done,
    output logic                          load_error,
    output logic [`ADDRESS_SIZE:0]        load_count
);

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        HOLD    = 3'd1,
        LOAD_HI = 3'd2,
        LOAD_LO = 3'd3,
        RUN     = 3'd4
    } state_t;

    // Last address of the clear sweep and the write-pointer value meaning "full".
    localparam logic [`ADDRESS_SIZE-1:0] LAST_ADDR = `ADDRESS_SIZE'(DEPTH - 1);
    localparam logic [`ADDRESS_SIZE:0]   FULL_PTR  = (`ADDRESS_SIZE + 1)'(DEPTH);

    state_t                         state_q, state_d;
    logic [`ADDRESS_SIZE-1:0]       clr_ptr_q, clr_ptr_d;
    logic [`ADDRESS_SIZE:0]         wr_ptr_q, wr_ptr_d;
    logic [7:0]                     hi_q, hi_d;
    logic                           core_reset_q, core_reset_d;
    logic                           done_q, done_d;
    logic                           error_q, error_d;
    logic [`ADDRESS_SIZE:0]         count_q, count_d;

    logic                           mem_we_s;
    logic [`ADDRESS_SIZE-1:0]       mem_addr_s;
    logic [`INSTRUCTION_SIZE-1:0]   mem_wdata_s;
    logic                           handshake_s;

    logic [`INSTRUCTION_SIZE-1:0]   mem [DEPTH];

    // Control registers; reset drops core_reset without waiting for a clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= CLEAR;
            clr_ptr_q    <= '0;
            wr_ptr_q     <= '0;
            hi_q         <= 8'h00;
            core_reset_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            hi_q         <= hi_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
            count_q      <= count_d;
        end
    end

    // Next-state logic for the clear sweep, the byte loader and run control.
    always_comb begin
        state_d      = state_q;
        clr_ptr_d    = clr_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        hi_d         = hi_q;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        error_d      = error_q;
        count_d      = count_q;
        mem_we_s     = 1'b0;
        mem_addr_s   = clr_ptr_q;
        mem_wdata_s  = `NOP;
        handshake_s  = load_valid && load_ready;

        case (state_q)
            CLEAR: begin
                mem_we_s     = 1'b1;
                clr_ptr_d    = clr_ptr_q + `ADDRESS_SIZE'(1);
                core_reset_d = 1'b0;
                done_d       = 1'b0;
                if (clr_ptr_q == LAST_ADDR) begin
                    state_d = HOLD;
                end else begin
                    state_d = CLEAR;
                end
            end
            HOLD: begin
                if (load_start) begin
                    state_d  = LOAD_HI;
                    error_d  = 1'b0;
                    count_d  = '0;
                    wr_ptr_d = '0;
                end else begin
                    state_d  = HOLD;
                end
            end
            LOAD_HI: begin
                if (load_start) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                    error_d   = 1'b1;
                end else if (handshake_s) begin
                    // A high byte with no room left, or flagged last, is an error.
                    if ((wr_ptr_q == FULL_PTR) || load_last) begin
                        state_d = HOLD;
                        error_d = 1'b1;
                    end else begin
                        state_d = LOAD_LO;
                        hi_d    = load_byte;
                    end
                end else begin
                    state_d = LOAD_HI;
                end
            end
            LOAD_LO: begin
                if (load_start) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                    error_d   = 1'b1;
                end else if (handshake_s) begin
                    mem_we_s    = 1'b1;
                    mem_addr_s  = wr_ptr_q[`ADDRESS_SIZE-1:0];
                    mem_wdata_s = {hi_q, load_byte};
                    wr_ptr_d    = wr_ptr_q + (`ADDRESS_SIZE + 1)'(1);
                    count_d     = count_q + (`ADDRESS_SIZE + 1)'(1);
                    if (load_last) begin
                        state_d      = RUN;
                        core_reset_d = 1'b1;
                        done_d       = 1'b1;
                    end else begin
                        state_d = LOAD_HI;
                    end
                end else begin
                    state_d = LOAD_LO;
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d      = CLEAR;
                    clr_ptr_d    = '0;
                    core_reset_d = 1'b0;
                    done_d       = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d      = CLEAR;
                clr_ptr_d    = '0;
                core_reset_d = 1'b0;
                done_d       = 1'b0;
            end
        endcase
    end

    // Single write port shared by the clear sweep and the loader; not reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem[mem_addr_s] <= mem_wdata_s;
        end
    end

    // Fetch port: same-cycle read while running, NOP otherwise.
    always_comb begin
        if (state_q == RUN) begin
            instruction = mem[pc];
        end else begin
            instruction = `NOP;
        end
    end

    assign load_ready = (state_q == LOAD_HI) || (state_q == LOAD_LO);
    assign core_reset = core_reset_q;
    assign load_done  = done_q;
    assign load_error = error_q;
    assign load_count = count_q;

endmodule

// File: tb/tb_program_memory.sv
// Bench for program_memory: a transaction-level model of the loader and the
// stored program is compared against the DUT every falling edge, and directed
// literal checks pin down the key values.

`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 4
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 16
`endif
`ifndef NOP
`define NOP 16'hE000
`endif
`ifndef HALT
`define HALT 16'hF000
`endif
`ifndef LOADC
`define LOADC 4'h1
`endif
`ifndef R0
`define R0 4'h0
`endif
`ifndef R1
`define R1 4'h1
`endif

module tb_program_memory;

    localparam int DEPTH = 2**`ADDRESS_SIZE;
    localparam int AW    = `ADDRESS_SIZE;

    logic                          clock      = 1'b0;
    logic                          reset      = 1'b0;
    logic [AW-1:0]                 pc         = '0;
    logic                          load_start = 1'b0;
    logic                          load_valid = 1'b0;
    logic [7:0]                    load_byte  = 8'h00;
    logic                          load_last  = 1'b0;
    logic [`INSTRUCTION_SIZE-1:0]  instruction;
    logic                          core_reset;
    logic                          load_ready;
    logic                          load_done;
    logic                          load_error;
    logic [AW:0]                   load_count;

    int total = 0;
    int bad   = 0;

    program_memory dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .instruction (instruction),
        .core_reset  (core_reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_byte   (load_byte),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .load_error  (load_error),
        .load_count  (load_count)
    );

    always #5 clock = ~clock;

    // Model: what the memory holds and what phase the loader is in.
    logic [15:0] m_mem [DEPTH];
    int          m_clear_left = DEPTH;
    bit          m_loading    = 1'b0;
    bit          m_have_hi    = 1'b0;
    bit          m_run        = 1'b0;
    bit          m_err        = 1'b0;
    int          m_cnt        = 0;
    int          m_ptr        = 0;
    logic [7:0]  m_hi         = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update from the inputs seen at each rising edge.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_clear_left <= DEPTH;
            m_loading    <= 1'b0;
            m_have_hi    <= 1'b0;
            m_run        <= 1'b0;
            m_err        <= 1'b0;
            m_cnt        <= 0;
            m_ptr        <= 0;
        end else if (m_clear_left > 0) begin
            m_clear_left <= m_clear_left - 1;
            if (m_clear_left == 1) begin
                for (int i = 0; i < DEPTH; i++) m_mem[i] <= `NOP;
            end
        end else if (m_run) begin
            if (load_start) begin
                m_run        <= 1'b0;
                m_clear_left <= DEPTH;
            end
        end else if (!m_loading) begin
            if (load_start) begin
                m_loading <= 1'b1;
                m_have_hi <= 1'b0;
                m_err     <= 1'b0;
                m_cnt     <= 0;
                m_ptr     <= 0;
            end
        end else if (load_start) begin
            m_loading    <= 1'b0;
            m_err        <= 1'b1;
            m_clear_left <= DEPTH;
        end else if (load_valid) begin
            if (!m_have_hi) begin
                if (m_ptr == DEPTH || load_last) begin
                    m_err     <= 1'b1;
                    m_loading <= 1'b0;
                end else begin
                    m_hi      <= load_byte;
                    m_have_hi <= 1'b1;
                end
            end else begin
                m_mem[m_ptr] <= {m_hi, load_byte};
                m_ptr        <= m_ptr + 1;
                m_cnt        <= m_cnt + 1;
                m_have_hi    <= 1'b0;
                if (load_last) begin
                    m_loading <= 1'b0;
                    m_run     <= 1'b1;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clock) begin
        check("instruction", instruction, m_run ? m_mem[pc] : `NOP);
        check("core_reset",  core_reset,  m_run);
        check("load_done",   load_done,   m_run);
        check("load_ready",  load_ready,  m_loading);
        check("load_error",  load_error,  m_err);
        check("load_count",  load_count,  m_cnt);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        bit done;
        done       = 1'b0;
        load_byte  = b;
        load_last  = last;
        load_valid = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            if (load_ready === 1'b1) done = 1'b1;
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=no_handshake expected=handshake byte=%0h", b);
        end
    endtask

    task automatic send_word(input logic [15:0] w, input bit last);
        send(w[15:8], 1'b0);
        send(w[7:0], last);
    endtask

    task automatic wait_clear;
        repeat (DEPTH + 2) tick();
    endtask

    logic [15:0] prog [9];

    initial begin
        // 1: reset and clear sweep
        repeat (2) tick();
        check("rst_core_reset", core_reset, 1'b0);
        check("rst_load_ready", load_ready, 1'b0);
        check("rst_load_count", load_count, 5'd0);
        reset = 1'b1;
        repeat (DEPTH) tick();
        check("hold_ready", load_ready, 1'b0);
        check("hold_core_reset", core_reset, 1'b0);
        for (int i = 0; i < 8; i++) begin
            pc = AW'(i);
            #1;
            check("hold_nop", instruction, `NOP);
            tick();
        end

        // 2: two-word program
        pulse_start();
        check("load_ready_on", load_ready, 1'b1);
        send({`LOADC, `R0}, 1'b0);
        send(8'h0D, 1'b0);
        send({`LOADC, `R1}, 1'b0);
        send(8'h0E, 1'b1);
        check("t2_count", load_count, 5'd2);
        check("t2_core_reset", core_reset, 1'b1);
        check("t2_done", load_done, 1'b1);
        pc = 4'd0; #1; check("t2_pc0", instruction, 16'h100D);
        pc = 4'd1; #1; check("t2_pc1", instruction, 16'h110E);
        pc = 4'd2; #1; check("t2_pc2", instruction, `NOP);
        tick();

        // 3: stalls and valid toggling without ready
        pulse_start();
        check("t3_core_reset_off", core_reset, 1'b0);
        wait_clear();
        for (int i = 0; i < 4; i++) begin
            load_valid = ~load_valid;
            load_byte  = 8'hFF;
            tick();
        end
        load_valid = 1'b0;
        check("t3_count_kept", load_count, 5'd2);
        pulse_start();
        send(8'h12, 1'b0);
        repeat (3) tick();
        check("t3_count_stall", load_count, 5'd0);
        send(8'h34, 1'b0);
        check("t3_count_one", load_count, 5'd1);
        send_word(16'h5678, 1'b1);
        pc = 4'd0; #1; check("t3_pc0", instruction, 16'h1234);
        pc = 4'd1; #1; check("t3_pc1", instruction, 16'h5678);
        tick();

        // 4: odd-length stream
        pulse_start();
        wait_clear();
        pulse_start();
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b1);
        check("t4_error", load_error, 1'b1);
        check("t4_ready", load_ready, 1'b0);
        check("t4_core_reset", core_reset, 1'b0);
        check("t4_count", load_count, 5'd1);

        // 5: overflow
        pulse_start();
        check("t5_error_cleared", load_error, 1'b0);
        for (int i = 0; i < 2 * DEPTH + 1; i++) send(8'(i), 1'b0);
        check("t5_error", load_error, 1'b1);
        check("t5_count", load_count, 5'd16);
        load_valid = 1'b1;
        load_byte  = 8'hEE;
        check("t5_ready_off", load_ready, 1'b0);
        tick();
        load_valid = 1'b0;
        check("t5_count_after", load_count, 5'd16);

        // 6: asynchronous reset in RUN and mid-load, then a 9-word reload
        pulse_start();
        send_word(16'h1111, 1'b1);
        check("t6_running", core_reset, 1'b1);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("t6_async_core_reset", core_reset, 1'b0);
        check("t6_async_done", load_done, 1'b0);
        tick();
        reset = 1'b1;
        wait_clear();
        pulse_start();
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("t6_midload_core_reset", core_reset, 1'b0);
        check("t6_midload_ready", load_ready, 1'b0);
        tick();
        reset = 1'b1;
        wait_clear();
        for (int i = 0; i < 8; i++) prog[i] = {`LOADC, 4'(i), 8'(8'h40 + i)};
        prog[8] = `HALT;
        pulse_start();
        for (int i = 0; i < 9; i++) send_word(prog[i], i == 8);
        check("t6_count", load_count, 5'd9);
        for (int i = 0; i < 9; i++) begin
            pc = AW'(i);
            tick();
        end
        pc = 4'd0; #1; check("t6_pc0", instruction, 16'h1040);
        pc = 4'd8; #1; check("t6_pc8_halt", instruction, `HALT);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
